// File: rtl/mem_responder_if.sv
// Core memory bus and loader signals between the stack core and mem_responder.
interface mem_responder_if;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_data_in;
  logic       load_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       cpu_hold;
  logic [7:0] load_count;
  logic       load_overflow;
  logic       wr_fault;

  modport master (
    output cpu_addr, cpu_wdata,
    output load_en, load_valid, load_data,
    input  cpu_data_in, cpu_hold,
    input  load_count, load_overflow, wr_fault
  );

  modport slave (
    input  cpu_addr, cpu_wdata,
    input  load_en, load_valid, load_data,
    output cpu_data_in, cpu_hold,
    output load_count, load_overflow, wr_fault
  );
endinterface

// File: rtl/mem_responder.sv
// RAM, 0xFF-marker store decoder and byte-serial loader for the 8-bit stack core.
// MEMRESP_WRITE_PROTECT_EN: drop CPU writes below PROT_BASE and flag wr_fault.
module mem_responder #(
  parameter int DEPTH     = 32,
  parameter int PROT_BASE = 16
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  prev_q, prev_d;
  logic        hold_q, hold_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        fault_q, fault_d;

  logic [7:0]    mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          addr_ok;
  logic          load_full;

  assign addr_ok   = {1'b0, bus.cpu_addr} < 9'(DEPTH);
  assign load_full = cnt_q >= 9'(DEPTH);

  assign bus.cpu_data_in   = addr_ok ? mem[bus.cpu_addr[AW-1:0]] : 8'h00;
  assign bus.cpu_hold      = hold_q;
  assign bus.load_count    = cnt_q[8] ? 8'hFF : cnt_q[7:0];
  assign bus.load_overflow = ovf_q;
  assign bus.wr_fault      = fault_q;

`ifndef MEMRESP_WRITE_PROTECT_EN
  logic unused_prot;
  assign unused_prot = (PROT_BASE == 0);
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = bus.cpu_wdata;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    fault_d = fault_q;
    we      = 1'b0;
    waddr   = bus.cpu_addr[AW-1:0];
    wdata   = bus.cpu_wdata;

    if (bus.load_en) begin
      state_d = LOAD;
      if (state_q != LOAD) begin
        cnt_d   = '0;
        ovf_d   = 1'b0;
        fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_wdata == 8'hFF && prev_q != 8'hFF)
            state_d = ARMED;
        end
        ARMED: begin
          state_d = IDLE;
          if (addr_ok) begin
`ifdef MEMRESP_WRITE_PROTECT_EN
            if ({24'h0, bus.cpu_addr} < PROT_BASE)
              fault_d = 1'b1;
            else
              we = 1'b1;
`else
            we = 1'b1;
`endif
          end
        end
        LOAD: begin
          state_d = IDLE;
          // a marker left on the bus during the load must not arm
          prev_d  = 8'hFF;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_q == LOAD && bus.load_valid) begin
      if (!load_full) begin
        we    = 1'b1;
        waddr = cnt_q[AW-1:0];
        wdata = bus.load_data;
        cnt_d = cnt_q + 9'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign hold_d = (state_d == LOAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 8'h00;
      hold_q  <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we)
      mem[waddr] <= wdata;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loader, store decoder, boundaries.
module tb_mem_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nerr  = 0;
  int   nchk  = 0;

  mem_responder_if bus ();

  mem_responder #(.DEPTH(32), .PROT_BASE(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

`ifdef MEMRESP_WRITE_PROTECT_EN
  localparam logic [7:0] EXP_M3 = 8'h83;
  localparam logic [7:0] EXP_WF = 8'h01;
`else
  localparam logic [7:0] EXP_M3 = 8'h5A;
  localparam logic [7:0] EXP_WF = 8'h00;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] a,
                    input logic [7:0] exp);
    bus.cpu_addr = a;
    #1;
    chk(tag, bus.cpu_data_in, exp);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] v);
    bus.cpu_wdata = 8'h00;
    tick();
    bus.cpu_wdata = 8'hFF;
    tick();
    bus.cpu_addr  = a;
    bus.cpu_wdata = v;
    tick();
    bus.cpu_wdata = 8'h00;
  endtask

  initial begin
    bus.cpu_addr   = 8'h00;
    bus.cpu_wdata  = 8'h00;
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    tick();
    tick();
    chk("rst_hold", {7'd0, bus.cpu_hold}, 8'h00);
    chk("rst_count", bus.load_count, 8'h00);
    chk("rst_ovf", {7'd0, bus.load_overflow}, 8'h00);
    chk("rst_wf", {7'd0, bus.wr_fault}, 8'h00);
    reset = 1'b0;

    // three-byte load
    bus.load_en = 1'b1;
    #1;
    chk("hold_pre", {7'd0, bus.cpu_hold}, 8'h00);
    tick();
    chk("hold_up", {7'd0, bus.cpu_hold}, 8'h01);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h0D;
    tick();
    bus.load_data  = 8'h07;
    tick();
    bus.load_data  = 8'h1A;
    tick();
    bus.load_valid = 1'b0;
    bus.load_en    = 1'b0;
    chk("count3", bus.load_count, 8'h03);
    chk("hold_lag", {7'd0, bus.cpu_hold}, 8'h01);
    tick();
    chk("hold_down", {7'd0, bus.cpu_hold}, 8'h00);
    rd("ld0", 8'h00, 8'h0D);
    rd("ld1", 8'h01, 8'h07);
    rd("ld2", 8'h02, 8'h1A);

    // basic store
    store(8'h14, 8'h2A);
    rd("st14", 8'h14, 8'h2A);

    // held marker arms once; moving the address later must not write
    bus.cpu_wdata = 8'h00;
    bus.cpu_addr  = 8'h00;
    tick();
    bus.cpu_wdata = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) bus.cpu_addr = 8'h01;
      tick();
    end
    bus.cpu_wdata = 8'h00;
    rd("ffhold0", 8'h00, 8'hFF);
    rd("ffhold1", 8'h01, 8'h07);

    // overflow load of DEPTH+2 bytes
    bus.load_en = 1'b1;
    tick();
    chk("ovl_cnt0", bus.load_count, 8'h00);
    bus.load_valid = 1'b1;
    for (int i = 0; i < 34; i++) begin
      bus.load_data = 8'(8'h80 + i);
      tick();
    end
    bus.load_valid = 1'b0;
    chk("ovl_cnt", bus.load_count, 8'd32);
    chk("ovl_flag", {7'd0, bus.load_overflow}, 8'h01);
    bus.load_en = 1'b0;
    tick();
    chk("ovl_sticky", {7'd0, bus.load_overflow}, 8'h01);
    rd("ovl_m0", 8'h00, 8'h80);
    rd("ovl_m3", 8'h03, 8'h83);
    rd("ovl_m31", 8'h1F, 8'h9F);

    // protected and unprotected stores
    store(8'h03, 8'h5A);
    rd("prot_m3", 8'h03, EXP_M3);
    chk("prot_wf", {7'd0, bus.wr_fault}, EXP_WF);
    store(8'h10, 8'h6B);
    rd("unprot_m16", 8'h10, 8'h6B);
    chk("unprot_wf", {7'd0, bus.wr_fault}, EXP_WF);

    // out-of-range store is dropped, not aliased
    store(8'h30, 8'h77);
    rd("oor_alias", 8'h10, 8'h6B);
    rd("oor_read", 8'h40, 8'h00);

    // load_en during ARMED discards the store
    bus.cpu_wdata = 8'h00;
    tick();
    bus.cpu_wdata = 8'hFF;
    tick();
    bus.cpu_addr  = 8'h11;
    bus.cpu_wdata = 8'h33;
    bus.load_en   = 1'b1;
    tick();
    chk("armld_hold", {7'd0, bus.cpu_hold}, 8'h01);
    chk("armld_wf", {7'd0, bus.wr_fault}, 8'h00);
    chk("armld_ovf", {7'd0, bus.load_overflow}, 8'h00);
    bus.cpu_wdata = 8'hFF;
    bus.load_en   = 1'b0;
    tick();
    rd("armld_m17", 8'h11, 8'h91);

    // marker on the bus at load exit must not arm
    bus.cpu_addr = 8'h12;
    tick();
    bus.cpu_wdata = 8'h44;
    tick();
    bus.cpu_wdata = 8'h00;
    rd("stale_m18", 8'h12, 8'h92);

    // reset mid-load
    bus.load_en = 1'b1;
    tick();
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hC1;
    tick();
    chk("mid_cnt1", bus.load_count, 8'h01);
    bus.load_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_hold", {7'd0, bus.cpu_hold}, 8'h00);
    chk("mid_cnt", bus.load_count, 8'h00);
    reset       = 1'b0;
    bus.load_en = 1'b0;
    tick();
    rd("mid_m0", 8'h00, 8'hC1);
    rd("mid_m1", 8'h01, 8'h81);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
